// File: rtl/writeback_arbiter.sv
// Writeback arbiter: formats the retiring primary result, merges secondary
// (multi-cycle producer) results through a small FIFO, and drives the
// register file write port from registered outputs. Primary always wins;
// secondary results drain in idle slots, and a younger primary write kills
// any queued secondary result to the same register.
module writeback_arbiter #(
  parameter int XLEN   = 32,
  parameter int AW     = 6,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  // primary datapath
  input  logic            p_valid,
  input  logic [AW-1:0]   p_rd,
  input  logic [1:0]      p_resultsrc,
  input  logic [XLEN-1:0] p_alu,
  input  logic [XLEN-1:0] p_rdata,
  input  logic [XLEN-1:0] p_pcplus4,
  input  logic [XLEN-1:0] p_imm,
  input  logic [2:0]      p_funct3,
  input  logic [1:0]      p_byteoff,
  // secondary producer
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [AW-1:0]   s_rd,
  input  logic [XLEN-1:0] s_data,
  // register file write port
  output logic            we3,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] wd3,
  output logic            load_misalign,
  output logic            stall_req
);

  localparam int IW = $clog2(QDEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_IMM  = 2'b11
  } resultsrc_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [AW-1:0]   q_rd   [QDEPTH];
  logic [XLEN-1:0] q_data [QDEPTH];
  logic            q_live [QDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic            q_full;
  logic            q_empty;
  logic [IW-1:0]   head_idx;
  logic [IW-1:0]   tail_idx;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_result;
  logic [XLEN-1:0] p_result;
  logic            p_is_load;
  logic            p_misalign;
  logic            p_write;
  logic            s_fire;
  logic            s_enq;
  logic            q_pop;

  assign head_idx = rd_ptr[IW-1:0];
  assign tail_idx = wr_ptr[IW-1:0];
  assign q_empty  = (wr_ptr == rd_ptr);
  assign q_full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  assign s_ready   = !q_full && !reset;
  assign stall_req = q_full;
  assign s_fire    = s_valid && s_ready;
  // rd=0 completes the handshake but is never stored
  assign s_enq     = s_fire && (s_rd != '0);

  assign p_is_load = (resultsrc_e'(p_resultsrc) == SRC_LOAD);

  // Misalignment detection for halfword and word loads
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    p_misalign = 1'b0;
    if (p_is_load) begin
      case (p_funct3)
        F3_LH, F3_LHU: p_misalign = p_byteoff[0];
        F3_LW:         p_misalign = (p_byteoff != 2'b00);
        default:       p_misalign = 1'b0;
      endcase
    end
  end

  // Byte/halfword lane extraction from the aligned memory word
  always_comb begin
    ld_byte = p_rdata[7:0];
    case (p_byteoff)
      2'd0: ld_byte = p_rdata[7:0];
      2'd1: ld_byte = p_rdata[15:8];
      2'd2: ld_byte = p_rdata[23:16];
      2'd3: ld_byte = p_rdata[31:24];
      default: ld_byte = p_rdata[7:0];
    endcase
    ld_half = p_byteoff[1] ? p_rdata[31:16] : p_rdata[15:0];
  end

  // Load sign/zero extension; unsupported funct3 passes the word through
  always_comb begin
    ld_result = p_rdata;
    case (p_funct3)
      F3_LB:   ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_result = p_rdata;
    endcase
  end

  // Primary result mux
  always_comb begin
    p_result = p_alu;
    case (resultsrc_e'(p_resultsrc))
      SRC_ALU:  p_result = p_alu;
      SRC_LOAD: p_result = ld_result;
      SRC_PC4:  p_result = p_pcplus4;
      SRC_IMM:  p_result = p_imm;
      default:  p_result = p_alu;
    endcase
  end

  assign p_write = p_valid && (p_rd != '0) && !p_misalign;
  // The FIFO head drains only in slots the primary does not use
  assign q_pop   = !p_write && !q_empty;

  // FIFO entry storage: kill same-rd entries on a primary write, then append
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; the pointers alone define occupancy, so stale contents are never observed.
    if (p_write) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_rd[i] == p_rd) q_live[i] <= 1'b0;
      end
    end
    // Enqueue comes after the kill loop so the new entry's live bit wins
    if (s_enq) begin
      q_rd[tail_idx]   <= s_rd;
      q_data[tail_idx] <= s_data;
      q_live[tail_idx] <= !(p_write && (p_rd == s_rd));
    end
  end

  // Pointers and registered write-port outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      we3           <= 1'b0;
      a3            <= '0;
      wd3           <= '0;
      load_misalign <= 1'b0;
    end else begin
      if (s_enq) wr_ptr <= wr_ptr + PW'(1);
      if (q_pop) rd_ptr <= rd_ptr + PW'(1);

      load_misalign <= p_valid && p_misalign;

      if (p_write) begin
        we3 <= 1'b1;
        a3  <= p_rd;
        wd3 <= p_result;
      end else if (q_pop && q_live[head_idx]) begin
        we3 <= 1'b1;
        a3  <= q_rd[head_idx];
        wd3 <= q_data[head_idx];
      end else begin
        // idle slot or a killed head popping without a write
        we3 <= 1'b0;
      end
    end
  end

endmodule
